// File: rtl/dvp_frame_scheduler_if.sv
// dvp_frame_scheduler_if: config, observed-handshake and status signals of the frame scheduler.
interface dvp_frame_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int FRM_CNT_W = 8,
    parameter int TMO_W = 24
);
    logic                 cfg_start_i;
    logic                 cfg_stop_i;
    logic                 cfg_cont_i;
    logic [FRM_CNT_W-1:0] cfg_frm_num_i;
    logic [ADDR_W-1:0]    cfg_base0_i;
    logic [ADDR_W-1:0]    cfg_base1_i;
    logic [TMO_W-1:0]     cfg_tmo_i;
    logic                 irq_clr_i;
    logic                 dvp_vsync_i;
    logic                 pxl_vld_i;
    logic                 pxl_rdy_i;
    logic                 awvalid_i;
    logic                 awready_i;
    logic                 bvalid_i;
    logic                 bready_i;
    logic                 cam_start_o;
    logic [ADDR_W-1:0]    pxl_base_o;
    logic                 buf_sel_o;
    logic [FRM_CNT_W-1:0] frm_idx_o;
    logic                 busy_o;
    logic                 frm_done_o;
    logic                 short_o;
    logic                 err_o;
    logic                 irq_o;
    modport master (
        output cfg_start_i, cfg_stop_i, cfg_cont_i, cfg_frm_num_i, cfg_base0_i, cfg_base1_i,
               cfg_tmo_i, irq_clr_i, dvp_vsync_i, pxl_vld_i, pxl_rdy_i, awvalid_i, awready_i,
               bvalid_i, bready_i,
        input  cam_start_o, pxl_base_o, buf_sel_o, frm_idx_o, busy_o, frm_done_o, short_o,
               err_o, irq_o
    );
    modport slave (
        input  cfg_start_i, cfg_stop_i, cfg_cont_i, cfg_frm_num_i, cfg_base0_i, cfg_base1_i,
               cfg_tmo_i, irq_clr_i, dvp_vsync_i, pxl_vld_i, pxl_rdy_i, awvalid_i, awready_i,
               bvalid_i, bready_i,
        output cam_start_o, pxl_base_o, buf_sel_o, frm_idx_o, busy_o, frm_done_o, short_o,
               err_o, irq_o
    );
endinterface

// File: rtl/dvp_frame_scheduler.sv
// dvp_frame_scheduler: gates capture on frame boundaries, ping-pongs buffer bases and
// waits for all AXI write responses before declaring each frame done.
module dvp_frame_scheduler #(
    parameter int FRM_PXL = 19200,
    parameter int PXL_CNT_W = 20,
    parameter int ADDR_W = 32,
    parameter int FRM_CNT_W = 8,
    parameter int TMO_W = 24,
    parameter int OUTSTD_W = 4
) (
    input logic clk,
    input logic rst,
    dvp_frame_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, CAPT, DRAIN, DONE, ERR} state_t;
    state_t state, state_n;
    logic vs_q, stop_q, cont_q;
    logic [PXL_CNT_W-1:0] pxl_cnt;
    logic [OUTSTD_W-1:0] outst, outst_n;
    logic [TMO_W-1:0] wd;
    logic [FRM_CNT_W-1:0] rem;
    logic [ADDR_W-1:0] next_base;
    logic vs_rise, pxl_hs, aw_hs, b_hs, load, last_pxl, active, tmo_hit;
    assign vs_rise = bus.dvp_vsync_i & ~vs_q;
    assign pxl_hs = bus.pxl_vld_i & bus.pxl_rdy_i;
    assign aw_hs = bus.awvalid_i & bus.awready_i;
    assign b_hs = bus.bvalid_i & bus.bready_i;
    assign load = (state == IDLE || state == ERR) && bus.cfg_start_i && !bus.cfg_stop_i;
    assign last_pxl = pxl_hs && pxl_cnt == PXL_CNT_W'(FRM_PXL - 1);
    assign active = state inside {ARM, CAPT, DRAIN};
    assign tmo_hit = active && bus.cfg_tmo_i != '0 && wd + 1'b1 == bus.cfg_tmo_i;
    assign next_base = bus.buf_sel_o ? bus.cfg_base0_i : bus.cfg_base1_i;
    // drain decision looks at the post-update count so DONE follows the last B edge directly
    assign outst_n = (aw_hs && !b_hs && outst != '1) ? outst + 1'b1 :
                     (b_hs && !aw_hs && outst != '0) ? outst - 1'b1 : outst;
    always_comb begin
        state_n = state;
        case (state)
            IDLE, ERR: state_n = load ? ARM : state;
            ARM:       state_n = bus.cfg_stop_i ? IDLE : vs_rise ? CAPT : tmo_hit ? ERR : ARM;
            CAPT:      state_n = (last_pxl || vs_rise) ? DRAIN : tmo_hit ? ERR : CAPT;
            DRAIN:     state_n = outst_n == '0 ? DONE : tmo_hit ? ERR : DRAIN;
            DONE:      state_n = (stop_q || (!cont_q && rem == '0)) ? IDLE : ARM;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vs_q <= 1'b0;
            stop_q <= 1'b0;
            cont_q <= 1'b0;
            pxl_cnt <= '0;
            outst <= '0;
            wd <= '0;
            rem <= '0;
            bus.cam_start_o <= 1'b0;
            bus.pxl_base_o <= '0;
            bus.buf_sel_o <= 1'b0;
            bus.frm_idx_o <= '0;
            bus.busy_o <= 1'b0;
            bus.frm_done_o <= 1'b0;
            bus.short_o <= 1'b0;
            bus.err_o <= 1'b0;
            bus.irq_o <= 1'b0;
        end else begin
            state <= state_n;
            vs_q <= bus.dvp_vsync_i;
            outst <= outst_n;
            pxl_cnt <= state == ARM ? '0 : (state == CAPT && pxl_hs) ? pxl_cnt + 1'b1 : pxl_cnt;
            wd <= (!active || state_n != state || pxl_hs || b_hs) ? '0 : wd + 1'b1;
            stop_q <= (state == IDLE || load) ? 1'b0 :
                      stop_q | (bus.cfg_stop_i && (state == CAPT || state == DRAIN));
            bus.cam_start_o <= state_n == CAPT;
            bus.busy_o <= !(state_n inside {IDLE, ERR});
            bus.frm_done_o <= state_n == DONE;
            bus.irq_o <= state_n == DONE || (state_n == ERR && state != ERR) ||
                         (bus.irq_o && !bus.irq_clr_i);
            bus.err_o <= !load && (bus.err_o || state_n == ERR);
            bus.short_o <= !load && (bus.short_o || (state == CAPT && state_n == DRAIN && !last_pxl));
            if (load) begin
                bus.pxl_base_o <= bus.cfg_base0_i;
                bus.buf_sel_o <= 1'b0;
                bus.frm_idx_o <= '0;
                rem <= bus.cfg_frm_num_i == '0 ? FRM_CNT_W'(1) : bus.cfg_frm_num_i;
                cont_q <= bus.cfg_cont_i;
            end else if (state_n == DONE) begin
                bus.pxl_base_o <= next_base;
                bus.buf_sel_o <= ~bus.buf_sel_o;
                bus.frm_idx_o <= bus.frm_idx_o + 1'b1;
                rem <= cont_q ? rem : rem - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dvp_frame_scheduler.sv
// tb_dvp_frame_scheduler: directed frames with a completion scoreboard checked on frm_done_o.
module tb_dvp_frame_scheduler;
    localparam int FRM_PXL = 16;
    localparam int PXL_CNT_W = 20;
    localparam int ADDR_W = 32;
    localparam int FRM_CNT_W = 8;
    localparam int TMO_W = 24;
    localparam int OUTSTD_W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dvp_frame_scheduler_if #(.ADDR_W(ADDR_W), .FRM_CNT_W(FRM_CNT_W), .TMO_W(TMO_W)) bus();
    dvp_frame_scheduler #(
        .FRM_PXL(FRM_PXL), .PXL_CNT_W(PXL_CNT_W), .ADDR_W(ADDR_W),
        .FRM_CNT_W(FRM_CNT_W), .TMO_W(TMO_W), .OUTSTD_W(OUTSTD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {
        int          idx;
        logic        bsel;
        logic [31:0] base;
        logic        sh;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int passes = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.frm_done_o) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got frm_done_o=1 expected no completion");
            end else begin
                e = q.pop_front();
                chk("done_idx", bus.frm_idx_o, e.idx);
                chk("done_buf_sel", bus.buf_sel_o, e.bsel);
                chk("done_base", bus.pxl_base_o, e.base);
                chk("done_short", bus.short_o, e.sh);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_pulse();
        bus.cfg_start_i = 1'b1;
        tick();
        bus.cfg_start_i = 1'b0;
    endtask
    task automatic clr_irq();
        bus.irq_clr_i = 1'b1;
        tick();
        bus.irq_clr_i = 1'b0;
    endtask
    task automatic expect_frame(input int idx, input logic bsel, input logic [31:0] base, input logic sh);
        exp_t e;
        e.idx = idx;
        e.bsel = bsel;
        e.base = base;
        e.sh = sh;
        q.push_back(e);
    endtask
    task automatic frame(input int npix, input int naw, input int bdelay, input logic [31:0] base,
                         input bit overlap, input bit stop_mid);
        int n, nb;
        bus.dvp_vsync_i = 1'b1;
        tick();
        bus.dvp_vsync_i = 1'b0;
        chk("cam_start_capt", bus.cam_start_o, 1);
        chk("base_capt", bus.pxl_base_o, base);
        for (int i = 0; i < npix; i++) begin
            bus.pxl_vld_i = 1'b1;
            bus.pxl_rdy_i = 1'b1;
            bus.awvalid_i = i < naw;
            bus.awready_i = i < naw;
            bus.bvalid_i = overlap && i == naw - 1;
            bus.bready_i = overlap && i == naw - 1;
            bus.cfg_stop_i = stop_mid && i == 5;
            tick();
        end
        {bus.pxl_vld_i, bus.pxl_rdy_i, bus.awvalid_i, bus.awready_i} = '0;
        {bus.bvalid_i, bus.bready_i, bus.cfg_stop_i} = '0;
        if (npix < FRM_PXL) begin
            chk("cam_still_on", bus.cam_start_o, 1);
            bus.dvp_vsync_i = 1'b1;
            tick();
            bus.dvp_vsync_i = 1'b0;
            chk("short_set", bus.short_o, 1);
        end
        chk("cam_off_drain", bus.cam_start_o, 0);
        chk("base_drain", bus.pxl_base_o, base);
        repeat (bdelay) tick();
        nb = overlap ? naw - 1 : naw;
        for (int i = 0; i < nb; i++) begin
            if (i == nb - 1) chk("no_done_before_last_b", bus.frm_done_o, 0);
            bus.bvalid_i = 1'b1;
            bus.bready_i = 1'b1;
            tick();
        end
        bus.bvalid_i = 1'b0;
        bus.bready_i = 1'b0;
        n = 0;
        while (!bus.frm_done_o && n < 100) begin
            tick();
            n++;
        end
        if (!bus.frm_done_o) begin
            checks++;
            $display("FAIL done_timeout: got no frm_done_o expected a pulse within 100 cycles");
        end
        tick();
        chk("done_pulse_width", bus.frm_done_o, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1);
    end
    initial begin
        {bus.cfg_start_i, bus.cfg_stop_i, bus.cfg_cont_i, bus.irq_clr_i, bus.dvp_vsync_i} = '0;
        {bus.pxl_vld_i, bus.pxl_rdy_i, bus.awvalid_i, bus.awready_i, bus.bvalid_i, bus.bready_i} = '0;
        bus.cfg_frm_num_i = 8'd1;
        bus.cfg_base0_i = 32'h1000;
        bus.cfg_base1_i = 32'h2000;
        bus.cfg_tmo_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_cam", bus.cam_start_o, 0);
        chk("rst_base", bus.pxl_base_o, 0);
        chk("rst_irq", bus.irq_o, 0);
        chk("rst_idx", bus.frm_idx_o, 0);
        // single frame
        start_pulse();
        chk("start_busy", bus.busy_o, 1);
        chk("arm_cam_off", bus.cam_start_o, 0);
        expect_frame(1, 1'b1, 32'h2000, 1'b0);
        frame(16, 4, 0, 32'h1000, 0, 0);
        chk("single_idle", bus.busy_o, 0);
        chk("single_idx", bus.frm_idx_o, 1);
        chk("single_buf", bus.buf_sel_o, 1);
        repeat (3) tick();
        chk("irq_level", bus.irq_o, 1);
        clr_irq();
        chk("irq_cleared", bus.irq_o, 0);
        // continuous, stop during third frame
        bus.cfg_cont_i = 1'b1;
        start_pulse();
        chk("cont_base_load", bus.pxl_base_o, 32'h1000);
        expect_frame(1, 1'b1, 32'h2000, 1'b0);
        frame(16, 2, 3, 32'h1000, 0, 0);
        expect_frame(2, 1'b0, 32'h1000, 1'b0);
        frame(16, 2, 0, 32'h2000, 0, 0);
        chk("cont_still_busy", bus.busy_o, 1);
        expect_frame(3, 1'b1, 32'h2000, 1'b0);
        frame(16, 2, 0, 32'h1000, 0, 1);
        chk("stop_idle", bus.busy_o, 0);
        bus.cfg_cont_i = 1'b0;
        clr_irq();
        // early vsync, frame count 0 treated as 1
        bus.cfg_frm_num_i = 8'd0;
        start_pulse();
        expect_frame(1, 1'b1, 32'h2000, 1'b1);
        frame(10, 2, 0, 32'h1000, 0, 0);
        chk("short_idle", bus.busy_o, 0);
        chk("short_sticky", bus.short_o, 1);
        // simultaneous AW/B and delayed responses
        bus.cfg_frm_num_i = 8'd1;
        start_pulse();
        chk("short_cleared", bus.short_o, 0);
        expect_frame(1, 1'b1, 32'h2000, 1'b0);
        frame(16, 4, 50, 32'h1000, 1, 0);
        chk("delay_idle", bus.busy_o, 0);
        clr_irq();
        // watchdog
        bus.cfg_tmo_i = 24'd100;
        start_pulse();
        bus.dvp_vsync_i = 1'b1;
        tick();
        bus.dvp_vsync_i = 1'b0;
        chk("wd_cam_on", bus.cam_start_o, 1);
        repeat (99) tick();
        chk("wd_not_yet", bus.err_o, 0);
        tick();
        chk("wd_err", bus.err_o, 1);
        chk("wd_cam_off", bus.cam_start_o, 0);
        chk("wd_busy_off", bus.busy_o, 0);
        chk("wd_irq", bus.irq_o, 1);
        bus.cfg_tmo_i = '0;
        clr_irq();
        start_pulse();
        chk("rearm_err_clr", bus.err_o, 0);
        chk("rearm_busy", bus.busy_o, 1);
        expect_frame(1, 1'b1, 32'h2000, 1'b0);
        frame(16, 1, 0, 32'h1000, 0, 0);
        // reset mid-capture with irq pending
        start_pulse();
        bus.dvp_vsync_i = 1'b1;
        tick();
        bus.dvp_vsync_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            {bus.pxl_vld_i, bus.pxl_rdy_i, bus.awvalid_i, bus.awready_i} = '1;
            tick();
        end
        {bus.pxl_vld_i, bus.pxl_rdy_i, bus.awvalid_i, bus.awready_i} = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cam", bus.cam_start_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_base", bus.pxl_base_o, 0);
        chk("mid_rst_idx", bus.frm_idx_o, 0);
        chk("mid_rst_irq", bus.irq_o, 0);
        chk("mid_rst_buf", bus.buf_sel_o, 0);
        start_pulse();
        expect_frame(1, 1'b1, 32'h2000, 1'b0);
        frame(16, 2, 0, 32'h1000, 0, 0);
        chk("post_rst_idle", bus.busy_o, 0);
        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
